mc_control: RTL
===============

# mc_control

Multi-cycle sequencing controller for the 16-bit MIPS-style core. It replaces single-cycle decoding with a Moore/Mealy state machine that steps one instruction through fetch, decode, execute, memory and write-back over several clocks. It also arbitrates the single shared memory port between instruction fetch and data access. The block drives the datapath mux selects and register enables, and consumes the instruction register opcode, the ALU zero flag and the memory acknowledge.

## Interface
Parameters:
- none (encodings live in the shared include)

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_instrCode  in  16  instruction register contents; opcode = [15:12]
- i_zero  in  1  ALU zero flag
- i_memAck  in  1  memory completes the access this cycle; may be combinational on o_memReq
- o_memReq  out  1  memory access request
- o_memWrite  out  1  request is a write (valid only with o_memReq)
- o_iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_irWrite  out  1  load instruction register
- o_pcWrite  out  1  unconditional PC load
- o_pcWriteCond  out  1  PC load if i_zero
- o_pcSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- o_aluSrcA  out  1  0 = PC, 1 = rs
- o_aluSrcB  out  2  00 rt, 01 constant 2, 10 sign-ext imm, 11 sign-ext imm<<1
- o_aluOp  out  2  00 add, 01 sub, 10 use funct
- o_regDst  out  1  write register: 0 = rt, 1 = rd
- o_memToReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- o_regWrite  out  1  register file write enable
- o_instrDone  out  1  one-cycle pulse in the last cycle of every instruction
- o_state  out  4  current state code (debug)

## Operation
- Opcodes: R 4'h0, LW 4'h1, SW 4'h2, BEQ 4'h3, ADDI 4'h4, J 4'h5; all others are illegal.
- States: RESET, FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
- RESET: all outputs 0. Always goes to FETCH on the next clock.
- FETCH: memReq=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00. irWrite and pcWrite = i_memAck (Mealy). The state holds until ack, then goes to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 to precompute the branch target into ALUOut. Next state by opcode:
  - LW/SW → MEMADDR
  - R → REXEC
  - ADDI → IEXEC
  - BEQ → BRANCH
  - J → JUMP
  - illegal → FETCH, with o_instrDone=1 (executes as NOP)
- MEMADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: memReq=1, iorD=1. Holds until ack, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0.
- MEMWR: memReq=1, memWrite=1, iorD=1. Holds until ack. o_instrDone = i_memAck.
- REXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Then RWB.
- RWB: regWrite=1, regDst=1, memToReg=0.
- IEXEC: aluSrcA=1, aluSrcB=10, aluOp=00. Then IWB.
- IWB: regWrite=1, regDst=0.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01.
- JUMP: pcWrite=1, pcSource=10.
- MEMWB, RWB, IWB, BRANCH and JUMP assert o_instrDone and return to FETCH.
- Every output not listed for a state is 0.

## Timing
- Reset is asynchronous: on i_rst_n low the state becomes RESET immediately and all outputs go to 0. A memory wait in progress is abandoned, and memReq drops in the same cycle.
- Cycle counts with zero-wait memory (ack in the request cycle), counted from FETCH:
  - J: 3
  - BEQ: 3
  - R: 4
  - ADDI: 4
  - SW: 4
  - LW: 5
  - illegal: 2
- Each memory wait cycle adds one clock.
- Request/ack handshake:
  - o_memReq stays high, with stable iorD and memWrite, until the cycle in which i_memAck=1.
  - i_memAck while o_memReq=0 is ignored.
- Mealy outputs are only irWrite, pcWrite (FETCH) and o_instrDone (MEMWR, DECODE-illegal). All other outputs are a registered-state decode.
- i_instrCode is sampled only in DECODE and MEMADDR. The IR is stable there because irWrite is 0 outside FETCH.

## Configuration
- MC_HALT_EN defined:
  - opcode 4'hF decodes as HALT; DECODE goes to a HALT state.
  - HALT drives all outputs 0 and asserts o_instrDone for one cycle on entry.
  - HALT is left only by reset.
  - Adds output o_halted (1 in HALT, reset 0).
- MC_HALT_EN undefined: 4'hF is illegal (NOP) and the o_halted port does not exist.

## Structure
- Shared include mc_defines.vh holds:
  - opcode constants
  - state codes (4-bit binary, RESET = 4'd0)
  - aluOp, aluSrcB and pcSource encodings
- One natural sub-module, mc_out_decode: combinational map from state, i_memAck and opcode to outputs. It is instantiated by mc_control, which keeps only the state register and next-state logic.

## Test plan
- Reset: assert i_rst_n=0 mid-MEMRD with memReq high → memReq and all outputs 0 the same cycle. After release: RESET for 1 cycle, then FETCH with memReq=1.
- ADD R-type (16'h0123), zero-wait → states FETCH, DECODE, REXEC, RWB. regWrite=1 with regDst=1 in cycle 4 only; o_instrDone at cycle 4.
- LW (16'h1234), ack delayed 2 cycles on both fetch and data → memReq held 3 cycles in each of FETCH and MEMRD, iorD=1 only in MEMRD, total 9 cycles, irWrite pulses exactly once.
- BEQ (16'h3xxx) with i_zero=1, then with i_zero=0 → BRANCH asserts pcWriteCond=1, pcSource=01, aluOp=01 in both cases; pcWrite=0 in BRANCH.
- Illegal opcode 16'h7000 → DECODE asserts o_instrDone, next state FETCH, regWrite and memReq never asserted.
- MC_HALT_EN build: 16'hF000 → HALT entered, o_halted=1, no further memReq for 20 cycles; reset clears o_halted to 0.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, state codes, mux selects, control word.
// MC_HALT_EN adds the HALT opcode (4'hF) as a legal instruction.
package mc_control_pkg;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_SW   = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_REXEC   = 4'd7,
        S_RWB     = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_HALT    = 4'd13
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ior_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
    } ctrl_t;

    // Anything not listed here retires in DECODE as a NOP.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
`ifdef MC_HALT_EN
            OP_HALT: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/memory bundle. master = controller side, slave = datapath side.
// MC_HALT_EN adds the o_halted status line.
interface mc_control_if;
    logic [15:0] i_instrCode;
    logic        i_zero;
    logic        i_memAck;
    logic        o_memReq;
    logic        o_memWrite;
    logic        o_iorD;
    logic        o_irWrite;
    logic        o_pcWrite;
    logic        o_pcWriteCond;
    logic [1:0]  o_pcSource;
    logic        o_aluSrcA;
    logic [1:0]  o_aluSrcB;
    logic [1:0]  o_aluOp;
    logic        o_regDst;
    logic        o_memToReg;
    logic        o_regWrite;
    logic        o_instrDone;
    logic [3:0]  o_state;
`ifdef MC_HALT_EN
    logic        o_halted;
`endif

    // Memory handshake: o_memReq with o_iorD/o_memWrite holds stable until the
    // cycle i_memAck=1 (ack may be combinational); i_memAck without o_memReq is ignored.
    modport master (
        input  i_instrCode, i_zero, i_memAck,
        output o_memReq, o_memWrite, o_iorD, o_irWrite, o_pcWrite, o_pcWriteCond,
               o_pcSource, o_aluSrcA, o_aluSrcB, o_aluOp, o_regDst, o_memToReg,
               o_regWrite, o_instrDone, o_state
`ifdef MC_HALT_EN
        , output o_halted
`endif
    );

    modport slave (
        output i_instrCode, i_zero, i_memAck,
        input  o_memReq, o_memWrite, o_iorD, o_irWrite, o_pcWrite, o_pcWriteCond,
               o_pcSource, o_aluSrcA, o_aluSrcB, o_aluOp, o_regDst, o_memToReg,
               o_regWrite, o_instrDone, o_state
`ifdef MC_HALT_EN
        , input o_halted
`endif
    );
endinterface

// File: rtl/mc_out_decode.sv
// Combinational control-word decode from state; only irWrite/pcWrite/instrDone look at inputs.
// MC_HALT_EN adds the HALT state decode.
module mc_out_decode
    import mc_control_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ack_i,
    input  logic [3:0] opcode_i,
`ifdef MC_HALT_EN
    input  logic       halt_first_i,
`endif
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SRCB_TWO;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ack_i;
                ctrl_o.pc_write  = mem_ack_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SH;
                ctrl_o.instr_done = !op_legal(opcode_i);
            end
            S_MEMADDR, S_IEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.ior_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.ior_d      = 1'b1;
                ctrl_o.instr_done = mem_ack_i;
            end
            S_REXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
`ifdef MC_HALT_EN
            S_HALT: ctrl_o.instr_done = halt_first_i;
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencer: state register + next-state logic; outputs come from mc_out_decode.
// MC_HALT_EN adds the HALT state (opcode 4'hF, exit by reset only) and o_halted.
module mc_control
    import mc_control_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    mc_control_if.master bus
);

    state_e     state_q;
    ctrl_t      ctrl;
    logic [3:0] opcode;

    assign opcode = bus.i_instrCode[15:12];

    // The remaining IR bits and the zero flag are consumed by the datapath, not here.
    logic unused_dp;
    assign unused_dp = &{1'b0, bus.i_instrCode[11:0], bus.i_zero};

`ifdef MC_HALT_EN
    logic halt_seen_q;
    logic halt_first;
    assign halt_first = (state_q == S_HALT) && !halt_seen_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_RESET;
`ifdef MC_HALT_EN
            halt_seen_q <= 1'b0;
`endif
        end else begin
`ifdef MC_HALT_EN
            halt_seen_q <= (state_q == S_HALT);
`endif
            case (state_q)
                S_RESET:  state_q <= S_FETCH;
                S_FETCH:  if (bus.i_memAck) state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADDR;
                        OP_R:         state_q <= S_REXEC;
                        OP_ADDI:      state_q <= S_IEXEC;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
`ifdef MC_HALT_EN
                        OP_HALT:      state_q <= S_HALT;
`endif
                        default:      state_q <= S_FETCH;
                    endcase
                end
                // Only LW and SW reach MEMADDR, so one opcode compare suffices.
                S_MEMADDR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (bus.i_memAck) state_q <= S_MEMWB;
                S_MEMWR:   if (bus.i_memAck) state_q <= S_FETCH;
                S_REXEC:   state_q <= S_RWB;
                S_IEXEC:   state_q <= S_IWB;
                S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
`ifdef MC_HALT_EN
                S_HALT:    state_q <= S_HALT;
`endif
                default:   state_q <= S_RESET;
            endcase
        end
    end

    mc_out_decode u_out_decode (
        .state_i      (state_q),
        .mem_ack_i    (bus.i_memAck),
        .opcode_i     (opcode),
`ifdef MC_HALT_EN
        .halt_first_i (halt_first),
`endif
        .ctrl_o       (ctrl)
    );

    assign bus.o_memReq      = ctrl.mem_req;
    assign bus.o_memWrite    = ctrl.mem_write;
    assign bus.o_iorD        = ctrl.ior_d;
    assign bus.o_irWrite     = ctrl.ir_write;
    assign bus.o_pcWrite     = ctrl.pc_write;
    assign bus.o_pcWriteCond = ctrl.pc_write_cond;
    assign bus.o_pcSource    = ctrl.pc_source;
    assign bus.o_aluSrcA     = ctrl.alu_src_a;
    assign bus.o_aluSrcB     = ctrl.alu_src_b;
    assign bus.o_aluOp       = ctrl.alu_op;
    assign bus.o_regDst      = ctrl.reg_dst;
    assign bus.o_memToReg    = ctrl.mem_to_reg;
    assign bus.o_regWrite    = ctrl.reg_write;
    assign bus.o_instrDone   = ctrl.instr_done;
    assign bus.o_state       = state_q;
`ifdef MC_HALT_EN
    assign bus.o_halted      = (state_q == S_HALT);
`endif

endmodule
